// File: rtl/spi_dac_multi.sv
`default_nettype none
// ============================================================================
// Module      : spi_dac_multi
// Description : Multi-channel serial DAC writer. A free-running frame counter
//               produces a sample tick (irq). On each tick all channel words
//               and the enable mask are latched, then one CS_N-framed word is
//               sent per enabled channel, lowest channel index first. DIN is
//               MSB first and changes on SCLK rising edges. The DAC samples
//               on falling edges.
// Optional    : define SPI_DAC_MULTI_LDAC_EN to add the LDAC_N output. It
//               pulses low for SCLK_DIV clk cycles after the last word's gap.
//               busy and done are delayed to the end of that pulse.
// Ports       : clk, rst_n            clock, async active-low reset
//               ch_data[NCH*WORD_W]   channel words, channel i at [i*WORD_W +: WORD_W]
//               ch_en[NCH]            channel enable mask, latched at the tick
//               CS_N, SCLK, DIN       DAC serial interface
//               LDAC_N                DAC load strobe (optional)
//               irq                   one-clk pulse per frame tick
//               busy, done            frame in progress / frame complete pulse
//               overrun, ovr_clr      sticky tick-while-busy flag and its clear
// Revision    : 1.0  initial release
// ============================================================================
module spi_dac_multi #(
  parameter int WORD_W    = 16,
  parameter int NCH       = 2,
  parameter int SCLK_DIV  = 2,
  parameter int CS_GAP    = 2,
  parameter int FRAME_DIV = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*WORD_W-1:0] ch_data,
  input  logic [NCH-1:0]        ch_en,
  output logic                  CS_N,
  output logic                  SCLK,
  output logic                  DIN,
  output logic                  irq,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
`ifdef SPI_DAC_MULTI_LDAC_EN
  output logic                  LDAC_N,
`endif
  input  logic                  ovr_clr
);

  localparam int H       = SCLK_DIV / 2;
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int TMR_MAX = (CS_GAP > SCLK_DIV) ? CS_GAP : SCLK_DIV;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int BIT_W   = $clog2(WORD_W);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(H - 1);
  localparam logic [TMR_W-1:0] TMR_GAP  = TMR_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
`ifdef SPI_DAC_MULTI_LDAC_EN
  localparam logic [TMR_W-1:0] TMR_LDAC = TMR_W'(2 * H - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4,
    S_LDAC  = 3'd5
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  tick;
  logic [NCH*WORD_W-1:0] shadow_q;
  logic [NCH-1:0]        mask_q;
  logic [CW-1:0]         ch_q;
  logic [WORD_W-1:0]     sh_q;
  logic [BIT_W-1:0]      bit_q;
  logic [TMR_W-1:0]      tmr_q;
  logic                  cs_n_q;
  logic                  sclk_q;
  logic                  din_q;
  logic                  irq_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  overrun_q;
`ifdef SPI_DAC_MULTI_LDAC_EN
  logic                  ldac_n_q;
`endif

  logic [CW-1:0]         first_idx;
  logic [CW-1:0]         next_idx;
  logic [NCH-1:0]        served_oh;
  logic [NCH-1:0]        rem_mask;
  logic [WORD_W-1:0]     first_word;
  logic [WORD_W-1:0]     next_word;

  // Index of the lowest set bit; returns 0 for an empty mask.
  function automatic logic [CW-1:0] lowest_idx(input logic [NCH-1:0] m);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) idx = CW'(i);
    end
    return idx;
  endfunction

  always_comb begin
    // The tick is taken on the last count so that irq, registered from it,
    // is high exactly while the counter reads 0.
    tick       = (cnt_q == CNT_LAST);
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    served_oh  = '0;
    served_oh[ch_q] = 1'b1;
    rem_mask   = mask_q & ~served_oh;
    first_idx  = lowest_idx(ch_en);
    next_idx   = lowest_idx(rem_mask);
    first_word = ch_data[first_idx*WORD_W +: WORD_W];
    next_word  = shadow_q[next_idx*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      mask_q    <= '0;
      ch_q      <= '0;
      sh_q      <= '0;
      bit_q     <= '0;
      tmr_q     <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      din_q     <= 1'b0;
      irq_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SPI_DAC_MULTI_LDAC_EN
      ldac_n_q  <= 1'b1;
`endif
    end else begin
      cnt_q  <= cnt_d;
      irq_q  <= tick;
      done_q <= 1'b0;

      // Any non-idle state counts as busy, including the last GAP cycle
      // right before IDLE. A new overrun event beats a clear.
      if (tick && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end else if (ovr_clr) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (tick) begin
            shadow_q <= ch_data;
            mask_q   <= ch_en;
            if (ch_en != '0) begin
              ch_q    <= first_idx;
              sh_q    <= first_word;
              busy_q  <= 1'b1;
              cs_n_q  <= 1'b0;
              sclk_q  <= 1'b0;
              din_q   <= 1'b0;
              tmr_q   <= TMR_HALF;
              state_q <= S_SETUP;
            end
          end
        end

        S_SETUP: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
          end else begin
            sclk_q  <= 1'b1;
            din_q   <= sh_q[WORD_W-1];
            sh_q    <= {sh_q[WORD_W-2:0], 1'b0};
            bit_q   <= '0;
            tmr_q   <= TMR_HALF;
            state_q <= S_SHIFT;
          end
        end

        // DIN holds its bit through the low half so the falling edge
        // samples a stable value.
        S_SHIFT: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
          end else if (sclk_q) begin
            sclk_q <= 1'b0;
            tmr_q  <= TMR_HALF;
          end else if (bit_q == BIT_LAST) begin
            din_q   <= 1'b0;
            tmr_q   <= TMR_HALF;
            state_q <= S_HOLD;
          end else begin
            sclk_q <= 1'b1;
            din_q  <= sh_q[WORD_W-1];
            sh_q   <= {sh_q[WORD_W-2:0], 1'b0};
            bit_q  <= bit_q + 1'b1;
            tmr_q  <= TMR_HALF;
          end
        end

        S_HOLD: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
          end else begin
            cs_n_q  <= 1'b1;
            tmr_q   <= TMR_GAP;
            state_q <= S_GAP;
          end
        end

        S_GAP: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
          end else begin
            mask_q <= rem_mask;
            if (rem_mask != '0) begin
              ch_q    <= next_idx;
              sh_q    <= next_word;
              cs_n_q  <= 1'b0;
              tmr_q   <= TMR_HALF;
              state_q <= S_SETUP;
            end else begin
`ifdef SPI_DAC_MULTI_LDAC_EN
              ldac_n_q <= 1'b0;
              tmr_q    <= TMR_LDAC;
              state_q  <= S_LDAC;
`else
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
`endif
            end
          end
        end

`ifdef SPI_DAC_MULTI_LDAC_EN
        S_LDAC: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
          end else begin
            ldac_n_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
`endif

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign CS_N    = cs_n_q;
  assign SCLK    = sclk_q;
  assign DIN     = din_q;
  assign irq     = irq_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;
`ifdef SPI_DAC_MULTI_LDAC_EN
  assign LDAC_N  = ldac_n_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_dac_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_dac_multi
// Description : Self-checking bench for spi_dac_multi. Two instances run side
//               by side: one with FRAME_DIV=100, where frames fit, and one
//               with FRAME_DIV=30, where ticks land mid-frame. A per-instance
//               model derives every output from the frame start cycle and the
//               word list by arithmetic on the cycle offset. A serial
//               receiver decodes instance 0 for the literal word checks.
// Optional    : honours SPI_DAC_MULTI_LDAC_EN (LDAC_N pulse, longer busy).
// Revision    : 1.0  initial release
// ============================================================================
module tb_spi_dac_multi;
  localparam int WORD_W   = 16;
  localparam int NCH      = 2;
  localparam int SCLK_DIV = 2;
  localparam int CS_GAP   = 2;
  localparam int H        = SCLK_DIV / 2;
  localparam int LEN      = 2 * H + WORD_W * SCLK_DIV;  // CS_N low cycles per word
  localparam int SLOT     = LEN + CS_GAP;               // cycles per word incl. gap
`ifdef SPI_DAC_MULTI_LDAC_EN
  localparam int TAIL = 2 * H;
`else
  localparam int TAIL = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NCH*WORD_W-1:0] ch_data = '0;
  logic [NCH-1:0]        ch_en = '0;
  logic                  ovr_clr = 1'b0;

  logic [1:0] cs_n, sclk, din, irq, busy, done, overrun;
`ifdef SPI_DAC_MULTI_LDAC_EN
  logic [1:0] ldac_n;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // DUT instances and behavioural models
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int FD = (g == 0) ? 100 : 30;

    spi_dac_multi #(
      .WORD_W(WORD_W), .NCH(NCH), .SCLK_DIV(SCLK_DIV),
      .CS_GAP(CS_GAP), .FRAME_DIV(FD)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ch_data (ch_data),
      .ch_en   (ch_en),
      .CS_N    (cs_n[g]),
      .SCLK    (sclk[g]),
      .DIN     (din[g]),
      .irq     (irq[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .overrun (overrun[g]),
`ifdef SPI_DAC_MULTI_LDAC_EN
      .LDAC_N  (ldac_n[g]),
`endif
      .ovr_clr (ovr_clr)
    );

    int  p;        // rising edges since reset release
    bit  act;      // a frame has been started
    int  s, e;     // frame start cycle, offset of the done pulse
    int  o, j, r, q;
    bit  ovr_m, tick_next, busy_now;
    logic e_cs, e_sc, e_di, e_bz, e_dn, e_ld;
    logic [WORD_W-1:0] wv;
    logic [WORD_W-1:0] words[$];

    always @(negedge clk) begin
      if (!rst_n) begin
        p = 0; act = 0; ovr_m = 0;
        words.delete();
        check("rst_cs_n", cs_n[g], 1'b1);
        check("rst_sclk", sclk[g], 1'b0);
        check("rst_din", din[g], 1'b0);
        check("rst_busy", busy[g], 1'b0);
        check("rst_ovr", overrun[g], 1'b0);
      end else begin
        e_cs = 1; e_sc = 0; e_di = 0; e_bz = 0; e_dn = 0; e_ld = 1;
        if (act) begin
          o = p - s;
          if (o < words.size() * SLOT) begin
            e_bz = 1;
            j = o / SLOT;
            r = o % SLOT;
            if (r < LEN) begin
              e_cs = 0;
              if (r >= H && r < H + WORD_W * SCLK_DIV) begin
                q    = r - H;
                wv   = words[j];
                e_sc = ((q % SCLK_DIV) < H);
                e_di = wv[WORD_W - 1 - q / SCLK_DIV];
              end
            end
          end else if (o < e) begin
            e_bz = 1;
            e_ld = 0;
          end else if (o == e) begin
            e_dn = 1;
          end
        end
        check("cs_n", cs_n[g], e_cs);
        check("sclk", sclk[g], e_sc);
        check("din", din[g], e_di);
        check("busy", busy[g], e_bz);
        check("done", done[g], e_dn);
        check("irq", irq[g], (p > 0) && (p % FD == 0));
        check("overrun", overrun[g], ovr_m);
`ifdef SPI_DAC_MULTI_LDAC_EN
        check("ldac_n", ldac_n[g], e_ld);
`endif
        // Decide what the coming clock edge does.
        tick_next = ((p + 1) % FD == 0);
        busy_now  = act && ((p - s) < e);
        if (tick_next && busy_now) begin
          ovr_m = 1;
        end else begin
          if (ovr_clr) ovr_m = 0;
          if (tick_next) begin
            words.delete();
            for (int i = 0; i < NCH; i++)
              if (ch_en[i]) words.push_back(ch_data[i*WORD_W +: WORD_W]);
            act = (words.size() != 0);
            s   = p + 1;
            e   = words.size() * SLOT + TAIL;
          end
        end
        p++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Serial receiver on instance 0: falling-edge sampling, CS_N framing
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] rx[$];
  int                win[$];
  logic [WORD_W-1:0] rx_sr;
  int                cs_len, busy_len, last_busy_len;
  logic              prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_sr = '0; cs_len = 0; busy_len = 0;
      prev_cs = 1'b1; prev_sclk = 1'b0; prev_busy = 1'b0;
    end else begin
      if (prev_sclk && !sclk[0] && !cs_n[0]) rx_sr = {rx_sr[WORD_W-2:0], din[0]};
      if (!cs_n[0]) cs_len++;
      if (!prev_cs && cs_n[0]) begin
        rx.push_back(rx_sr);
        win.push_back(cs_len);
        cs_len = 0;
      end
      if (busy[0]) busy_len++;
      if (prev_busy && !busy[0]) begin
        last_busy_len = busy_len;
        busy_len = 0;
      end
      prev_cs = cs_n[0]; prev_sclk = sclk[0]; prev_busy = busy[0];
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_sig0(input bit want_done, input int budget);
    int k;
    k = 0;
    while (k < budget) begin
      @(negedge clk);
      if (want_done ? done[0] : irq[0]) break;
      k++;
    end
    if (k >= budget) begin
      total++;
      bad++;
      $display("FAIL timeout waiting for %s", want_done ? "done" : "irq");
    end
  endtask

  int n_done, n_irq;

  initial begin
    // Reset, release just after a rising edge.
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    ch_data = {16'h8123, 16'h4ABC};
    ch_en   = 2'b11;

    // Both channels, channel 0 first.
    rx.delete(); win.delete();
    wait_sig0(1, 250);
    step(1);
    check("t1_nwords", rx.size(), 2);
    if (rx.size() == 2) begin
      check("t1_word0", rx[0], 16'h4ABC);
      check("t1_word1", rx[1], 16'h8123);
      check("t1_win0", win[0], 34);
      check("t1_win1", win[1], 34);
    end
    check("t1_busy_len", last_busy_len, 72 + TAIL);

    // Channel 1 only.
    ch_en = 2'b10;
    rx.delete(); win.delete();
    wait_sig0(1, 250);
    step(1);
    check("t2_nwords", rx.size(), 1);
    if (rx.size() == 1) check("t2_word", rx[0], 16'h8123);

    // Input change 5 clk after the tick must not leak into the frame.
    ch_en = 2'b11;
    rx.delete(); win.delete();
    wait_sig0(0, 250);
    step(5);
    ch_data = {$urandom, $urandom};
    wait_sig0(1, 250);
    step(1);
    check("t5_nwords", rx.size(), 2);
    if (rx.size() == 2) begin
      check("t5_word0", rx[0], 16'h4ABC);
      check("t5_word1", rx[1], 16'h8123);
    end

    // Empty mask: irq keeps ticking, nothing is sent, no done.
    ch_en = 2'b00;
    rx.delete();
    n_done = 0; n_irq = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done[0]) n_done++;
      if (irq[0]) n_irq++;
    end
    check("t3_done_cnt", n_done, 0);
    check("t3_irq_cnt", n_irq, 2);
    check("t3_nwords", rx.size(), 0);

    // The short-frame instance overran earlier; the other never did.
    check("t4_ovr_fast", overrun[1], 1'b1);
    check("t4_ovr_slow", overrun[0], 1'b0);
    step(1);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    @(negedge clk);
    check("t4_ovr_cleared", overrun[1], 1'b0);

    // Reset in the middle of a word.
    ch_data = {16'h8123, 16'h4ABC};
    ch_en   = 2'b11;
    wait_sig0(0, 250);
    step(10);
    #1;
    check("t6_in_word", cs_n[0], 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_async_cs_n", cs_n[0], 1'b1);
    check("t6_async_sclk", sclk[0], 1'b0);
    check("t6_async_din", din[0], 1'b0);
    check("t6_async_busy", busy[0], 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    rx.delete(); win.delete();
    wait_sig0(1, 300);
    step(1);
    check("t6_nwords", rx.size(), 2);
    if (rx.size() == 2) begin
      check("t6_word0", rx[0], 16'h4ABC);
      check("t6_word1", rx[1], 16'h8123);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step(1);
      if ($urandom_range(0, 7) == 0) ch_data = {$urandom, $urandom};
      if ($urandom_range(0, 39) == 0) ch_en = NCH'($urandom);
      ovr_clr = ($urandom_range(0, 19) == 0);
    end
    ovr_clr = 1'b0;
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
